// File: rtl/usb_spi_responder.sv
// Cycle-based MAX3421E SPI slave model: command/data framing, 32x8 register file, HIRQ/HIEN and INT pin.
// Optional build macro USB_SPI_AUTOINC_EN: post-increment the register address after every DATA byte.
module usb_spi_responder #(
  parameter int         SYNC_STAGES    = 2,
  parameter logic [7:0] REVISION_VAL   = 8'h13,
  parameter bit         INT_ACTIVE_LOW = 1'b0
) (
  input  logic       Clk,
  input  logic       reset_rtl_0,
  input  logic       usb_spi_sclk,
  input  logic       usb_spi_ss,
  input  logic       usb_spi_mosi,
  output logic       usb_spi_miso,
  input  logic       gpio_usb_rst_tri_o,
  output logic       gpio_usb_int_tri_i,
  input  logic [7:0] irq_set
);

  localparam logic [4:0] REG_REVISION = 5'd18;
  localparam logic [4:0] REG_HIRQ     = 5'd25;
  localparam logic [4:0] REG_HIEN     = 5'd26;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  logic rst;
  assign rst = reset_rtl_0 | ~gpio_usb_rst_tri_o;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_d, ss_d;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  // SS idles high so a reset never fabricates a select edge.
  // NOTE: every clocked block uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge Clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], usb_spi_sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], usb_spi_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], usb_spi_mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] rx, tx;
  logic [4:0] addr;
  logic       dir_wr;
  logic       skip_fall;
  logic [7:0] regs [32];

  logic [7:0] rx_next, w1c_mask, cmd_rd, data_rd;
  logic [4:0] next_addr;
  logic       byte_done, wr_en;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    rx_next   = {rx[6:0], mosi_s};
    byte_done = (state != IDLE) && sclk_rise && (bit_cnt == 3'd7);
    wr_en     = byte_done && (state == DATA) && dir_wr;
    w1c_mask  = (wr_en && addr == REG_HIRQ) ? rx_next : 8'h00;
`ifdef USB_SPI_AUTOINC_EN
    next_addr = addr + 5'd1;
`else
    next_addr = addr;
`endif
    cmd_rd    = regs[rx_next[7:3]];
    data_rd   = regs[next_addr];
  end

  // A byte load on the 8th rising edge already presents the next MSB, so the following fall must not shift.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      rx           <= 8'h00;
      tx           <= 8'h00;
      addr         <= 5'd0;
      dir_wr       <= 1'b0;
      skip_fall    <= 1'b0;
      usb_spi_miso <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          usb_spi_miso <= 1'b0;
          if (ss_fall) begin
            tx           <= regs[REG_HIRQ];
            usb_spi_miso <= regs[REG_HIRQ][7];
            bit_cnt      <= 3'd0;
            skip_fall    <= 1'b0;
            state        <= CMD;
          end
        end
        default: begin
          if (sclk_rise) begin
            rx      <= rx_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
              bit_cnt <= 3'd0;
              if (state == CMD) begin
                addr   <= rx_next[7:3];
                dir_wr <= rx_next[1];
                state  <= DATA;
                if (!rx_next[1]) begin
                  tx           <= cmd_rd;
                  usb_spi_miso <= cmd_rd[7];
                  skip_fall    <= 1'b1;
                end
              end else begin
                addr <= next_addr;
                if (!dir_wr) begin
                  tx           <= data_rd;
                  usb_spi_miso <= data_rd[7];
                  skip_fall    <= 1'b1;
                end
              end
            end
          end else if (sclk_fall) begin
            if (skip_fall) begin
              skip_fall <= 1'b0;
            end else begin
              tx           <= {tx[6:0], 1'b0};
              usb_spi_miso <= tx[6];
            end
          end
          // Placed last so a byte completing in the same cycle still commits before the abort.
          if (ss_rise) begin
            state        <= IDLE;
            usb_spi_miso <= 1'b0;
          end
        end
      endcase
    end
  end

  // NOTE: the register file is reset explicitly because its post-reset contents are visible to firmware.
  always_ff @(posedge Clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 18) ? REVISION_VAL : 8'h00;
      end
    end else begin
      if (wr_en && addr != REG_REVISION && addr != REG_HIRQ) begin
        regs[addr] <= rx_next;
      end
      regs[REG_HIRQ] <= (regs[REG_HIRQ] & ~w1c_mask) | irq_set;
    end
  end

  logic int_raw;
  assign int_raw = |(regs[REG_HIRQ] & regs[REG_HIEN]);

  always_ff @(posedge Clk) begin
    if (rst) begin
      gpio_usb_int_tri_i <= INT_ACTIVE_LOW;
    end else begin
      gpio_usb_int_tri_i <= int_raw ^ INT_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_usb_spi_responder.sv
// Self-checking bench for usb_spi_responder: directed scenarios plus random transactions against a transaction-level model.
module tb_usb_spi_responder;

  localparam bit INT_ACTIVE_LOW = 1'b0;
  localparam bit INT_ON         = !INT_ACTIVE_LOW;
  localparam int HALF           = 6;
`ifdef USB_SPI_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_rtl_0 = 1'b1;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       chip_rst_n = 1'b1;
  logic       int_pin;
  logic [7:0] irq_set = 8'h00;

  always #5 clk = ~clk;

  usb_spi_responder #(
    .SYNC_STAGES   (2),
    .REVISION_VAL  (8'h13),
    .INT_ACTIVE_LOW(INT_ACTIVE_LOW)
  ) dut (
    .Clk               (clk),
    .reset_rtl_0       (reset_rtl_0),
    .usb_spi_sclk      (sclk),
    .usb_spi_ss        (ss),
    .usb_spi_mosi      (mosi),
    .usb_spi_miso      (miso),
    .gpio_usb_rst_tri_o(chip_rst_n),
    .gpio_usb_int_tri_i(int_pin),
    .irq_set           (irq_set)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tx_buf  [4];
  logic [7:0] rx_buf  [4];
  logic [7:0] exp_buf [4];
  logic [7:0] m_regs  [32];
  bit         mon_int  = 1'b0;
  bit         int_drop = 1'b0;

  // ---------------- reference model (transaction level) ----------------
  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    m_regs[18] = 8'h13;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    if (a == 25)      m_regs[25] = m_regs[25] & ~d;
    else if (a != 18) m_regs[a] = d;
  endtask

  task automatic model_xact(input int nbits);
    int nb = nbits / 8;
    int a  = int'(tx_buf[0][7:3]);
    bit wr = tx_buf[0][1];
    exp_buf[0] = m_regs[25];
    for (int i = 1; i < nb; i++) begin
      if (wr) model_write(a, tx_buf[i]);
      else    exp_buf[i] = m_regs[a];
      if (AUTOINC) a = (a + 1) % 32;
    end
  endtask

  function automatic logic exp_int();
    return (|(m_regs[25] & m_regs[26])) ? INT_ON : !INT_ON;
  endfunction

  // ---------------- SPI master driver ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half_wait();
    repeat (HALF) begin
      @(negedge clk);
      if (mon_int && int_pin !== INT_ON) int_drop = 1'b1;
    end
  endtask

  task automatic spi_xact(input int nbits);
    ss = 1'b0;
    wait_clk(8);
    for (int b = 0; b < nbits; b++) begin
      mosi = tx_buf[b / 8][7 - (b % 8)];
      half_wait();
      rx_buf[b / 8][7 - (b % 8)] = miso;
      sclk = 1'b1;
      half_wait();
      sclk = 1'b0;
    end
    half_wait();
    ss = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    tx_buf[0] = b0;
    tx_buf[1] = b1;
    tx_buf[2] = b2;
    tx_buf[3] = 8'h00;
  endtask

  task automatic xact(input int nbits);
    model_xact(nbits);
    spi_xact(nbits);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_rtl_0 = 1'b1;
    wait_clk(8);
    reset_rtl_0 = 1'b0;
    model_reset();
    wait_clk(2);
    n_checks++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", miso); end
    n_checks++;
    if (int_pin !== !INT_ON) begin n_fail++; $display("FAIL reset_int: got %b expected %b", int_pin, !INT_ON); end
    set_tx(8'h90, 8'h00, 8'h00);
    xact(16);
    n_checks++;
    if (rx_buf[0] !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h expected 00", rx_buf[0]); end
    n_checks++;
    if (rx_buf[1] !== 8'h13) begin n_fail++; $display("FAIL reset_revision: got %h expected 13", rx_buf[1]); end
    n_checks++;
    if (int_pin !== !INT_ON) begin n_fail++; $display("FAIL reset_int_after: got %b expected %b", int_pin, !INT_ON); end
  endtask

  task automatic test_write_readback();
    set_tx(8'hD2, 8'hA5, 8'h00); xact(16);
    set_tx(8'hD0, 8'h00, 8'h00); xact(16);
    n_checks++;
    if (rx_buf[1] !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_hien: got %h expected a5", rx_buf[1]); end
    set_tx(8'h92, 8'hFF, 8'h00); xact(16);
    set_tx(8'h90, 8'h00, 8'h00); xact(16);
    n_checks++;
    if (rx_buf[1] !== 8'h13) begin n_fail++; $display("FAIL revision_ro: got %h expected 13", rx_buf[1]); end
    n_checks++;
    if (rx_buf[0] !== exp_buf[0]) begin n_fail++; $display("FAIL wr_rd_status: got %h expected %h", rx_buf[0], exp_buf[0]); end
  endtask

  task automatic test_interrupt();
    set_tx(8'hD2, 8'h01, 8'h00); xact(16);
    n_checks++;
    if (int_pin !== !INT_ON) begin n_fail++; $display("FAIL int_idle: got %b expected %b", int_pin, !INT_ON); end
    irq_set = 8'h01;
    @(negedge clk);
    irq_set = 8'h00;
    m_regs[25] = m_regs[25] | 8'h01;
    n_checks++;
    if (int_pin !== !INT_ON) begin n_fail++; $display("FAIL int_latency_early: got %b expected %b", int_pin, !INT_ON); end
    @(negedge clk);
    n_checks++;
    if (int_pin !== INT_ON) begin n_fail++; $display("FAIL int_latency_assert: got %b expected %b", int_pin, INT_ON); end
    set_tx(8'h00, 8'h00, 8'h00); xact(16);
    n_checks++;
    if (rx_buf[0] !== 8'h01) begin n_fail++; $display("FAIL int_status: got %h expected 01", rx_buf[0]); end
    set_tx(8'hCA, 8'h01, 8'h00); xact(16);
    n_checks++;
    if (int_pin !== !INT_ON) begin n_fail++; $display("FAIL int_w1c_clear: got %b expected %b", int_pin, !INT_ON); end
  endtask

  task automatic test_collision();
    irq_set = 8'h01;
    wait_clk(4);
    int_drop = 1'b0;
    mon_int  = 1'b1;
    set_tx(8'hCA, 8'h01, 8'h00); xact(16);
    mon_int = 1'b0;
    irq_set = 8'h00;
    m_regs[25] = m_regs[25] | 8'h01;
    wait_clk(2);
    n_checks++;
    if (int_drop !== 1'b0) begin n_fail++; $display("FAIL collision_int_glitch: got drop=%b expected 0", int_drop); end
    n_checks++;
    if (int_pin !== INT_ON) begin n_fail++; $display("FAIL collision_int: got %b expected %b", int_pin, INT_ON); end
    set_tx(8'h00, 8'h00, 8'h00); xact(16);
    n_checks++;
    if (rx_buf[0] !== 8'h01) begin n_fail++; $display("FAIL collision_hirq: got %h expected 01", rx_buf[0]); end
    set_tx(8'hCA, 8'h01, 8'h00); xact(16);
    n_checks++;
    if (int_pin !== exp_int()) begin n_fail++; $display("FAIL collision_clear: got %b expected %b", int_pin, exp_int()); end
  endtask

  task automatic test_abort();
    set_tx(8'h0A, 8'h3C, 8'h00);
    xact(12);
    n_checks++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL abort_miso: got %b expected 0", miso); end
    set_tx(8'h08, 8'h00, 8'h00); xact(16);
    n_checks++;
    if (rx_buf[1] !== 8'h00) begin n_fail++; $display("FAIL abort_reg1: got %h expected 00", rx_buf[1]); end
    n_checks++;
    if (rx_buf[0] !== exp_buf[0]) begin n_fail++; $display("FAIL abort_status: got %h expected %h", rx_buf[0], exp_buf[0]); end
  endtask

  task automatic test_multi_read();
    logic [7:0] e2;
    set_tx(8'h22, 8'h11, 8'h00); xact(16);
    set_tx(8'h2A, 8'h22, 8'h00); xact(16);
    set_tx(8'h20, 8'h00, 8'h00); xact(24);
    e2 = AUTOINC ? 8'h22 : 8'h11;
    n_checks++;
    if (rx_buf[1] !== 8'h11) begin n_fail++; $display("FAIL multi_byte0: got %h expected 11", rx_buf[1]); end
    n_checks++;
    if (rx_buf[2] !== e2) begin n_fail++; $display("FAIL multi_byte1: got %h expected %h", rx_buf[2], e2); end
    set_tx(8'hFA, 8'h5A, 8'h00); xact(16);
    set_tx(8'h02, 8'h77, 8'h00); xact(16);
    set_tx(8'hF8, 8'h00, 8'h00); xact(24);
    e2 = AUTOINC ? 8'h77 : 8'h5A;
    n_checks++;
    if (rx_buf[1] !== 8'h5A) begin n_fail++; $display("FAIL wrap_byte0: got %h expected 5a", rx_buf[1]); end
    n_checks++;
    if (rx_buf[2] !== e2) begin n_fail++; $display("FAIL wrap_byte1: got %h expected %h", rx_buf[2], e2); end
  endtask

  task automatic test_idle_sclk();
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom_range(0, 1));
      wait_clk(HALF);
      sclk = ~sclk;
    end
    mosi = 1'b0;
    wait_clk(4);
    n_checks++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL idle_sclk_miso: got %b expected 0", miso); end
    set_tx(8'h20, 8'h00, 8'h00); xact(16);
    n_checks++;
    if (rx_buf[1] !== exp_buf[1]) begin n_fail++; $display("FAIL idle_sclk_read: got %h expected %h", rx_buf[1], exp_buf[1]); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int nd;
      logic [7:0] cmd, irq;
      if ($urandom_range(0, 3) == 0) begin
        irq = 8'($urandom);
        irq_set = irq;
        @(negedge clk);
        irq_set = 8'h00;
        m_regs[25] = m_regs[25] | irq;
        wait_clk(3);
      end
      cmd = {5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0};
      nd  = $urandom_range(1, 3);
      set_tx(cmd, 8'($urandom), 8'($urandom));
      tx_buf[3] = 8'($urandom);
      xact((nd + 1) * 8);
      for (int i = 0; i <= nd; i++) begin
        if (i == 0 || !cmd[1]) begin
          n_checks++;
          if (rx_buf[i] !== exp_buf[i]) begin
            n_fail++;
            $display("FAIL rand_xact%0d cmd %h byte%0d: got %h expected %h", t, cmd, i, rx_buf[i], exp_buf[i]);
          end
        end
      end
      n_checks++;
      if (int_pin !== exp_int()) begin n_fail++; $display("FAIL rand_int%0d: got %b expected %b", t, int_pin, exp_int()); end
    end
  endtask

  task automatic test_chip_reset();
    set_tx(8'h1A, 8'h5A, 8'h00); xact(16);
    chip_rst_n = 1'b0;
    wait_clk(4);
    chip_rst_n = 1'b1;
    model_reset();
    wait_clk(2);
    n_checks++;
    if (int_pin !== !INT_ON) begin n_fail++; $display("FAIL chip_rst_int: got %b expected %b", int_pin, !INT_ON); end
    set_tx(8'h18, 8'h00, 8'h00); xact(16);
    n_checks++;
    if (rx_buf[1] !== 8'h00) begin n_fail++; $display("FAIL chip_rst_reg3: got %h expected 00", rx_buf[1]); end
    n_checks++;
    if (rx_buf[0] !== 8'h00) begin n_fail++; $display("FAIL chip_rst_status: got %h expected 00", rx_buf[0]); end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_interrupt();
    test_collision();
    test_abort();
    test_multi_read();
    test_idle_sclk();
    test_random();
    test_chip_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
